// File: rtl/trans_ledger_validator.sv
// Transaction ledger validator: looks up or allocates sender/receiver accounts in a
// synchronous-read table, checks funds and overflow, then commits or rejects.
module trans_ledger_validator #(
  parameter  int ID_W     = 48,
  parameter  int AMT_W    = 22,
  parameter  int BAL_W    = 24,
  parameter  int FLAG_W   = 10,
  parameter  int DEPTH    = 16384,
  parameter  int INIT_BAL = 100,
  localparam int DATA_W   = 2*ID_W + AMT_W + FLAG_W,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              reject_o,
  output logic [1:0]        reason_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [BAL_W-1:0] INIT_B = BAL_W'(INIT_BAL);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_ALLOC, S_CHECK, S_WR_SND, S_WR_RCV
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   pkt_q;
  logic [CNT_W-1:0]    count_q, new_cnt_q, idx_q;
  logic                s_found_q, r_found_q, full_q;
  logic [ADDR_W-1:0]   s_addr_q, r_addr_q;
  logic [BAL_W-1:0]    s_bal_q, r_bal_q;
  logic                valid_q, reject_q;
  logic [1:0]          reason_q;

  logic [ID_W+BAL_W-1:0] mem [DEPTH];
  logic [ID_W+BAL_W-1:0] rd_q;

  logic [ID_W-1:0]   snd_id, rcv_id, rd_id;
  logic [AMT_W-1:0]  amt;
  logic [BAL_W-1:0]  amt_ext, rd_bal;
  logic              self_xfer;

  assign snd_id    = pkt_q[DATA_W-1 -: ID_W];
  assign rcv_id    = pkt_q[DATA_W-ID_W-1 -: ID_W];
  assign amt       = pkt_q[FLAG_W +: AMT_W];
  assign amt_ext   = BAL_W'(amt);
  assign self_xfer = (snd_id == rcv_id);
  assign rd_id     = rd_q[BAL_W +: ID_W];
  assign rd_bal    = rd_q[BAL_W-1:0];

  // Search compare: rd_q holds the entry at idx_q (address issued one cycle earlier).
  logic              cmp_valid, s_hit, r_hit, s_found_d, r_found_d, search_done_d;
  logic [ADDR_W-1:0] raddr_d;

  always_comb begin
    cmp_valid     = (idx_q < count_q);
    s_hit         = cmp_valid && !s_found_q && (rd_id == snd_id);
    r_hit         = cmp_valid && !r_found_q && (rd_id == rcv_id);
    s_found_d     = s_found_q | s_hit;
    r_found_d     = r_found_q | r_hit;
    search_done_d = (count_q == '0) || (s_found_d && r_found_d) ||
                    (idx_q == count_q - CNT_W'(1));
    raddr_d       = '0;
    if (state_q == S_SEARCH) raddr_d = ADDR_W'(idx_q + CNT_W'(1));
  end

  logic             need_s, need_r, full_d;
  logic [CNT_W:0]   alloc_sum_d;

  always_comb begin
    need_s      = !s_found_q;
    need_r      = !self_xfer && !r_found_q;
    alloc_sum_d = (CNT_W+1)'(count_q) + (CNT_W+1)'(need_s) + (CNT_W+1)'(need_r);
    full_d      = (alloc_sum_d > (CNT_W+1)'(DEPTH));
  end

  logic           insuff_d, ovf_d;
  logic [BAL_W:0] r_sum_d;

  // A self-transfer nets to zero, so the receiver overflow test does not apply to it.
  always_comb begin
    insuff_d = (s_bal_q < amt_ext);
    r_sum_d  = {1'b0, r_bal_q} + {1'b0, amt_ext};
    ovf_d    = !self_xfer && r_sum_d[BAL_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pkt_q     <= '0;
      count_q   <= '0;
      new_cnt_q <= '0;
      idx_q     <= '0;
      s_found_q <= 1'b0;
      r_found_q <= 1'b0;
      full_q    <= 1'b0;
      s_addr_q  <= '0;
      r_addr_q  <= '0;
      s_bal_q   <= '0;
      r_bal_q   <= '0;
      valid_q   <= 1'b0;
      reject_q  <= 1'b0;
      reason_q  <= '0;
    end else begin
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      reason_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            pkt_q     <= data_i;
            if (data_i[FLAG_W-1]) count_q <= '0;
            idx_q     <= '0;
            s_found_q <= 1'b0;
            r_found_q <= 1'b0;
            full_q    <= 1'b0;
            state_q   <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          s_found_q <= s_found_d;
          r_found_q <= r_found_d;
          if (s_hit) begin
            s_addr_q <= idx_q[ADDR_W-1:0];
            s_bal_q  <= rd_bal;
          end
          if (r_hit) begin
            r_addr_q <= idx_q[ADDR_W-1:0];
            r_bal_q  <= rd_bal;
          end
          idx_q <= idx_q + CNT_W'(1);
          if (search_done_d) state_q <= S_ALLOC;
        end
        S_ALLOC: begin
          // Allocation is staged in new_cnt_q; count_q only moves on commit.
          if (full_d) begin
            full_q <= 1'b1;
          end else begin
            if (need_s) begin
              s_addr_q <= count_q[ADDR_W-1:0];
              s_bal_q  <= INIT_B;
            end
            if (need_r) begin
              r_addr_q <= count_q[ADDR_W-1:0] + ADDR_W'(need_s);
              r_bal_q  <= INIT_B;
            end
            new_cnt_q <= alloc_sum_d[CNT_W-1:0];
          end
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (full_q) begin
            reject_q <= 1'b1;
            reason_q <= 2'd2;
            state_q  <= S_IDLE;
          end else if (insuff_d) begin
            reject_q <= 1'b1;
            reason_q <= 2'd1;
            state_q  <= S_IDLE;
          end else if (ovf_d) begin
            reject_q <= 1'b1;
            reason_q <= 2'd3;
            state_q  <= S_IDLE;
          end else begin
            valid_q <= 1'b1;
            count_q <= new_cnt_q;
            if (!self_xfer) begin
              s_bal_q <= s_bal_q - amt_ext;
              r_bal_q <= r_sum_d[BAL_W-1:0];
            end
            state_q <= S_WR_SND;
          end
        end
        S_WR_SND: state_q <= self_xfer ? S_IDLE : S_WR_RCV;
        S_WR_RCV: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ID_W+BAL_W-1:0] wr_data;

  always_comb begin
    wr_en   = (state_q == S_WR_SND) || (state_q == S_WR_RCV);
    wr_addr = (state_q == S_WR_SND) ? s_addr_q : r_addr_q;
    wr_data = (state_q == S_WR_SND) ? {snd_id, s_bal_q} : {rcv_id, r_bal_q};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[raddr_d];
  end

  assign ready_o  = (state_q == S_IDLE);
  assign data_o   = pkt_q;
  assign valid_o  = valid_q;
  assign reject_o = reject_q;
  assign reason_o = reason_q;
  assign count_o  = count_q;

endmodule

// File: tb/tb_trans_ledger_validator.sv
// Directed bench for trans_ledger_validator: three instances (default, 8-bit balance,
// 4-entry table) driven through hand-computed transactions.
module tb_trans_ledger_validator;

  logic clk, rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [127:0] d0, d2, do0, do2;
  logic [113:0] d1, do1;
  logic v0, v1, v2, rdy0, rdy1, rdy2, vo0, vo1, vo2, ro0, ro1, ro2;
  logic [1:0] rs0, rs1, rs2;
  logic [14:0] c0, c1;
  logic [2:0]  c2;

  trans_ledger_validator u0 (
    .clk(clk), .rst(rst), .data_i(d0), .valid_i(v0), .ready_o(rdy0), .data_o(do0),
    .valid_o(vo0), .reject_o(ro0), .reason_o(rs0), .count_o(c0));

  trans_ledger_validator #(.AMT_W(8), .BAL_W(8), .INIT_BAL(250)) u1 (
    .clk(clk), .rst(rst), .data_i(d1), .valid_i(v1), .ready_o(rdy1), .data_o(do1),
    .valid_o(vo1), .reject_o(ro1), .reason_o(rs1), .count_o(c1));

  trans_ledger_validator #(.DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .data_i(d2), .valid_i(v2), .ready_o(rdy2), .data_o(do2),
    .valid_o(vo2), .reject_o(ro2), .reason_o(rs2), .count_o(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic f_rdy(input int i);
    case (i) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
  endfunction
  function automatic logic f_vo(input int i);
    case (i) 0: return vo0; 1: return vo1; default: return vo2; endcase
  endfunction
  function automatic logic f_ro(input int i);
    case (i) 0: return ro0; 1: return ro1; default: return ro2; endcase
  endfunction
  function automatic logic [1:0] f_rsn(input int i);
    case (i) 0: return rs0; 1: return rs1; default: return rs2; endcase
  endfunction
  function automatic logic [15:0] f_cnt(input int i);
    case (i) 0: return 16'(c0); 1: return 16'(c1); default: return 16'(c2); endcase
  endfunction
  function automatic logic [127:0] f_do(input int i);
    case (i) 0: return do0; 1: return 128'(do1); default: return do2; endcase
  endfunction

  function automatic logic [127:0] mkpkt(input int inst, input logic [47:0] s,
                                          input logic [47:0] r, input int amt, input bit bs);
    logic [113:0] p1;
    if (inst == 1) begin
      p1 = {s, r, amt[7:0], bs, 9'b0};
      return 128'(p1);
    end
    return {s, r, amt[21:0], bs, 9'b0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp_res: 1 commit, 2 reject. exp_lat counts negedges from acceptance to the pulse.
  task automatic txn(input int inst, input logic [47:0] s, input logic [47:0] r,
                     input int amt, input bit bs, input int exp_res, input int exp_rsn,
                     input int exp_lat, input string tag);
    logic [127:0] pkt;
    logic [1:0]   rsn;
    int n, lat, res;
    n = 0;
    while (!f_rdy(inst) && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, f_rdy(inst), 1);
    pkt = mkpkt(inst, s, r, amt, bs);
    case (inst)
      0:       begin d0 = pkt; v0 = 1'b1; end
      1:       begin d1 = pkt[113:0]; v1 = 1'b1; end
      default: begin d2 = pkt; v2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    lat = 0; res = 0; rsn = '0;
    while (res == 0 && lat < 50) begin
      @(negedge clk);
      lat++;
      if (f_vo(inst) && f_ro(inst)) res = 3;
      else if (f_vo(inst)) begin res = 1; rsn = f_rsn(inst); end
      else if (f_ro(inst)) begin res = 2; rsn = f_rsn(inst); end
    end
    chk({tag, "_result"}, res, exp_res);
    chk({tag, "_reason"}, rsn, exp_rsn);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data_o"}, f_do(inst), pkt);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {f_vo(inst), f_ro(inst)}, 2'b00);
    if (exp_res == 1) chk({tag, "_ready_after"}, f_rdy(inst), (s == r));
  endtask

  localparam logic [47:0] A = 48'h1, B = 48'h2, C = 48'h3, D = 48'h4, E = 48'h5,
                          F = 48'h6, G = 48'h7, H = 48'h8;
  localparam logic [47:0] P = 48'h10, Q = 48'h11, R = 48'h12, S = 48'h13,
                          X = 48'h20, Y = 48'h21;

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy0, 1);
    chk("rst_valid", vo0, 0);
    chk("rst_reject", ro0, 0);
    chk("rst_reason", rs0, 0);
    chk("rst_count", c0, 0);
    chk("rst_data", do0, 0);

    // Default instance: basic ledger flow
    txn(0, A, B, 30, 0, 1, 0, 4, "T1_AB30");
    chk("T1_count", f_cnt(0), 2);
    txn(0, A, C, 80, 0, 2, 1, 5, "T2_AC80");
    chk("T2_count", f_cnt(0), 2);
    txn(0, B, A, 131, 0, 2, 1, 5, "T3_BA131");
    txn(0, A, B, 71, 0, 2, 1, 5, "T4_AB71");
    txn(0, A, B, 70, 0, 1, 0, 5, "T5_AB70");
    txn(0, B, A, 200, 0, 1, 0, 5, "T6_BA200");
    chk("T6_count", f_cnt(0), 2);
    txn(0, F, F, 50, 0, 1, 0, 5, "T7_FF50");
    chk("T7_count", f_cnt(0), 3);
    txn(0, F, A, 101, 0, 2, 1, 6, "T8_FA101");
    txn(0, D, E, 5, 1, 1, 0, 4, "T9_DE5_bs");
    chk("T9_count", f_cnt(0), 2);
    txn(0, D, E, 96, 0, 2, 1, 5, "T10_DE96");
    txn(0, E, D, 106, 0, 2, 1, 5, "T11_ED106");
    txn(0, E, D, 105, 0, 1, 0, 5, "T12_ED105");
    chk("T12_count", f_cnt(0), 2);

    // 8-bit balances, INIT_BAL 250
    txn(1, A, B, 10, 0, 2, 3, 4, "U1_AB10");
    chk("U1_count0", f_cnt(1), 0);
    txn(1, A, B, 5, 0, 1, 0, 4, "U1_AB5");
    chk("U1_count2", f_cnt(1), 2);
    txn(1, A, B, 1, 0, 2, 3, 5, "U1_AB1");
    txn(1, A, A, 246, 0, 2, 1, 4, "U1_AA246");
    txn(1, A, A, 245, 0, 1, 0, 4, "U1_AA245");
    chk("U1_count_end", f_cnt(1), 2);

    // 4-entry table
    txn(2, P, Q, 1, 0, 1, 0, 4, "U2_PQ");
    txn(2, R, R, 1, 0, 1, 0, 5, "U2_RR");
    chk("U2_count3", f_cnt(2), 3);
    txn(2, S, P, 1, 0, 1, 0, 6, "U2_SP");
    chk("U2_count4", f_cnt(2), 4);
    txn(2, X, Y, 1, 0, 2, 2, 7, "U2_XY_full");
    txn(2, P, X, 500, 0, 2, 2, 7, "U2_PX_full_prio");
    chk("U2_count_full", f_cnt(2), 4);
    txn(2, P, Q, 1, 0, 1, 0, 5, "U2_PQ_existing");
    chk("U2_count_end", f_cnt(2), 4);

    // Reset in the middle of a search
    n = 0;
    while (!rdy0 && n < 50) begin @(negedge clk); n++; end
    chk("R_ready_pre", rdy0, 1);
    d0 = mkpkt(0, G, H, 3, 0);
    v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("R_ready", rdy0, 1);
    chk("R_count", c0, 0);
    chk("R_data", do0, 0);
    chk("R_pulses", {vo0, ro0, rs0}, 4'b0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (vo0 || ro0) seen = 1'b1;
    end
    chk("R_no_pulse", seen, 0);
    chk("R_count_after", c0, 0);
    txn(0, A, B, 30, 0, 1, 0, 4, "R_AB30");
    chk("R_count_end", f_cnt(0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
